// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read-side consumer feeding a 2-entry valid/ready output buffer
// One read in flight at a time; error-flagged returns are dropped and counted.
module fifo_rd_stream #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             enable,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_rd_data,
   input  logic             fifo_rd_err,
   output logic             fifo_rd_en,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [CNT_W-1:0] deliver_cnt,
   output logic [CNT_W-1:0] drop_cnt
);

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   occ_t             occ_q, occ_d;
   logic             rd_en_q, rd_en_d;
   logic             pend_q, pend_d;
   logic             ret_q;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] dlv_q, dlv_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic             push, pop, issue, overflow, drop_inc;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         occ_q   <= OCC_EMPTY;
         rd_en_q <= 1'b0;
         pend_q  <= 1'b0;
         ret_q   <= 1'b0;
         head_q  <= '0;
         tail_q  <= '0;
         dlv_q   <= '0;
         drop_q  <= '0;
      end else begin
         occ_q   <= occ_d;
         rd_en_q <= rd_en_d;
         pend_q  <= pend_d;
         ret_q   <= rd_en_q;
         head_q  <= head_d;
         tail_q  <= tail_d;
         dlv_q   <= dlv_d;
         drop_q  <= drop_d;
      end
   end

   always_comb begin
      occ_d    = occ_q;
      head_d   = head_q;
      tail_d   = tail_q;
      overflow = 1'b0;
      pop      = (occ_q != OCC_EMPTY) && out_ready;
      push     = ret_q && !fifo_rd_err;
      // pend covers the request cycle and the return cycle
      issue    = enable && !fifo_empty && !pend_q && (occ_q != OCC_TWO);
      rd_en_d  = issue;
      pend_d   = issue || (pend_q && !ret_q);

      case (occ_q)
         OCC_EMPTY: begin
            if (push) begin
               head_d = fifo_rd_data;
               occ_d  = OCC_ONE;
            end
         end
         OCC_ONE: begin
            if (push && pop) begin
               head_d = fifo_rd_data;
            end else if (push) begin
               tail_d = fifo_rd_data;
               occ_d  = OCC_TWO;
            end else if (pop) begin
               occ_d  = OCC_EMPTY;
            end
         end
         OCC_TWO: begin
            if (pop) begin
               head_d = tail_q;
               if (push) begin
                  tail_d = fifo_rd_data;
               end else begin
                  occ_d  = OCC_ONE;
               end
            end else if (push) begin
               overflow = 1'b1;
            end
         end
         default: occ_d = OCC_EMPTY;
      endcase

      drop_inc = (ret_q && fifo_rd_err) || overflow;
      dlv_d    = (pop && (dlv_q != CNT_MAX)) ? dlv_q + CNT_ONE : dlv_q;
      drop_d   = (drop_inc && (drop_q != CNT_MAX)) ? drop_q + CNT_ONE : drop_q;
   end

   assign fifo_rd_en  = rd_en_q;
   assign out_valid   = (occ_q != OCC_EMPTY);
   assign out_data    = head_q;
   assign deliver_cnt = dlv_q;
   assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - randomized bench for fifo_rd_stream against a queue-based model
// Two instances share stimulus: default counters and 4-bit saturating counters.
module tb_fifo_rd_stream;
   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] data;
      logic         err;
   } word_t;

   logic          CLK = 1'b0;
   logic          nRST = 1'b0;
   logic          enable = 1'b0;
   logic          fifo_empty = 1'b1;
   logic [W-1:0]  fifo_rd_data = '0;
   logic          fifo_rd_err = 1'b0;
   logic          out_ready = 1'b0;

   logic          fifo_rd_en, out_valid;
   logic [W-1:0]  out_data;
   logic [15:0]   deliver_cnt, drop_cnt;
   logic          rd_en_s, valid_s;
   logic [W-1:0]  data_s;
   logic [3:0]    dlv_s, drop_s;

   fifo_rd_stream #(.WIDTH(W), .CNT_W(16)) u_dut (
      .CLK(CLK), .nRST(nRST), .enable(enable), .fifo_empty(fifo_empty),
      .fifo_rd_data(fifo_rd_data), .fifo_rd_err(fifo_rd_err), .fifo_rd_en(fifo_rd_en),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .deliver_cnt(deliver_cnt), .drop_cnt(drop_cnt)
   );

   fifo_rd_stream #(.WIDTH(W), .CNT_W(4)) u_sat (
      .CLK(CLK), .nRST(nRST), .enable(enable), .fifo_empty(fifo_empty),
      .fifo_rd_data(fifo_rd_data), .fifo_rd_err(fifo_rd_err), .fifo_rd_en(rd_en_s),
      .out_valid(valid_s), .out_data(data_s), .out_ready(out_ready),
      .deliver_cnt(dlv_s), .drop_cnt(drop_s)
   );

   always #5 CLK = ~CLK;

   word_t        src_q[$];
   logic [W-1:0] exp_q[$];
   word_t        ret_word;
   bit           ret_now, issue_exp, prev_valid;
   int           n_dlv, n_drop, n_rd, cyc, last_rd, rd_seen, rise_seen;
   int           ready_pct, enable_pct, glitch_pct;
   int           n_checks = 0;
   int           n_fail = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int sat(input int v, input int m);
      return (v > m) ? m : v;
   endfunction

   task automatic model_clear();
      exp_q.delete();
      src_q.delete();
      n_dlv = 0; n_drop = 0; n_rd = 0;
      ret_now = 0; issue_exp = 0; prev_valid = 0;
      last_rd = cyc - 10; rd_seen = -100; rise_seen = -100;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_rd_en"}, {fifo_rd_en, rd_en_s}, 0);
      check_eq({tag, "_valid"}, {out_valid, valid_s}, 0);
      check_eq({tag, "_data"}, {out_data, data_s}, 0);
      check_eq({tag, "_cnts"}, {deliver_cnt, drop_cnt, dlv_s, drop_s}, 0);
   endtask

   task automatic add_src(input logic [W-1:0] d, input logic e);
      word_t w;
      w.data = d;
      w.err  = e;
      src_q.push_back(w);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      nRST = 0; enable = 0; fifo_empty = 1; out_ready = 0;
      model_clear();
      @(negedge CLK);
      check_all_zero("reset");
      nRST = 1;
   endtask

   // One clock: check this cycle's outputs, then drive and model the closing edge.
   task automatic cycle();
      int occ_now;
      @(negedge CLK);
      cyc++;
      check_eq("rd_en", fifo_rd_en, issue_exp);
      check_eq("rd_en_sat", rd_en_s, issue_exp);
      check_eq("valid", out_valid, exp_q.size() != 0);
      check_eq("valid_sat", valid_s, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
         check_eq("data", out_data, exp_q[0]);
         check_eq("data_sat", data_s, exp_q[0]);
      end
      check_eq("deliver_cnt", deliver_cnt, sat(n_dlv, 65535));
      check_eq("drop_cnt", drop_cnt, sat(n_drop, 65535));
      check_eq("deliver_sat", dlv_s, sat(n_dlv, 15));
      check_eq("drop_sat", drop_s, sat(n_drop, 15));
      if (out_valid && !prev_valid) rise_seen = cyc;
      prev_valid = out_valid;
      occ_now = exp_q.size();

      out_ready = ($urandom_range(99) < ready_pct);
      if (ret_now) begin
         fifo_rd_data = ret_word.data;
         fifo_rd_err  = ret_word.err;
      end else begin
         fifo_rd_data = $urandom;
         fifo_rd_err  = 1'($urandom_range(1));
      end
      if (exp_q.size() != 0 && out_ready) begin
         void'(exp_q.pop_front());
         n_dlv++;
      end
      if (ret_now) begin
         if (ret_word.err || exp_q.size() == 2) n_drop++;
         else exp_q.push_back(ret_word.data);
      end
      if (fifo_rd_en) begin
         n_rd++;
         rd_seen = cyc;
         last_rd = cyc;
         if (src_q.size() != 0) ret_word = src_q.pop_front();
         else begin
            ret_word.data = $urandom;
            ret_word.err  = 1'b0;
         end
      end
      ret_now    = fifo_rd_en;
      enable     = ($urandom_range(99) < enable_pct);
      fifo_empty = (src_q.size() == 0) || ($urandom_range(99) < glitch_pct);
      // a read is in flight during its request cycle and its return cycle
      issue_exp  = enable && !fifo_empty && (cyc - last_rd >= 2) && (occ_now != 2);
   endtask

   initial begin
      cyc = 0;
      ready_pct = 100; enable_pct = 100; glitch_pct = 0;
      model_clear();

      // idle with empty FIFO
      do_reset();
      repeat (10) cycle();
      check_eq("t1_no_reads", n_rd, 0);

      // single word, out_valid two cycles after the read pulse
      do_reset();
      add_src(32'hDEADBEEF, 1'b0);
      repeat (12) cycle();
      check_eq("t2_reads", n_rd, 1);
      check_eq("t2_latency", rise_seen - rd_seen, 2);
      check_eq("t2_deliver", deliver_cnt, 1);

      // backpressure fills exactly two entries
      do_reset();
      ready_pct = 0;
      add_src(32'd1, 1'b0); add_src(32'd2, 1'b0); add_src(32'd3, 1'b0);
      repeat (15) cycle();
      check_eq("t3_reads", n_rd, 2);
      check_eq("t3_head", {out_valid, out_data}, {1'b1, 32'd1});
      ready_pct = 100;
      repeat (20) cycle();
      check_eq("t3_deliver", deliver_cnt, 3);

      // error-flagged word dropped, next word delivered
      do_reset();
      add_src(32'h55, 1'b1); add_src(32'h66, 1'b0);
      repeat (20) cycle();
      check_eq("t4_drop", drop_cnt, 1);
      check_eq("t4_deliver", deliver_cnt, 1);

      // async reset the cycle after a read pulse
      do_reset();
      add_src(32'hA5A5A5A5, 1'b0);
      for (int i = 0; i < 10 && n_rd == 0; i++) cycle();
      check_eq("t5_read_seen", n_rd, 1);
      @(posedge CLK);
      #2 nRST = 0;
      #1 check_all_zero("t5_async");
      model_clear();
      enable = 1; fifo_empty = 1;
      repeat (2) @(negedge CLK);
      nRST = 1;
      repeat (10) cycle();
      check_eq("t5_no_ghost", n_dlv, 0);
      add_src(32'h12345678, 1'b0);
      repeat (10) cycle();
      check_eq("t5_new_word", deliver_cnt, 1);

      // randomized traffic, long enough to saturate the 4-bit counters
      do_reset();
      ready_pct = 60; enable_pct = 80; glitch_pct = 20;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(99) < 40) add_src($urandom, ($urandom_range(99) < 30));
         cycle();
      end
      check_eq("t6_enough_words", n_dlv >= 20 && n_drop >= 16, 1);
      check_eq("t6_deliver_held", dlv_s, 15);
      check_eq("t6_drop_held", drop_s, 15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
